// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP transmit-path types and constants
package udp_pkg;
    localparam int UDP_HDR_BYTES = 8;
    typedef logic [15:0] udp_port_t;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} arb_state_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: first set request at or after ptr, scanning upward modulo N
// Ports: req (request vector), ptr (highest-priority index), found (any request), idx (winning index)
module rr_priority_select #(
    parameter int N  = 2,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          found,
    output logic [GW-1:0] idx
);
    logic [GW-1:0] cand;
    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            cand = GW'((32'(ptr) + 32'(k)) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-level round-robin share of one udp_tx engine among NUM_PORTS clients
// Ports: i_clk/i_reset_n (sync active-low); s_udp_hdr_* / s_tx_axis_* packed per-client header and payload;
//        m_udp_hdr_* / m_tx_axis_* to udp_tx; o_busy (packet granted); o_grant (current/last granted client)
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int AXI_DATA_WIDTH = 8,
    localparam int GRANT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic [NUM_PORTS-1:0]                s_udp_hdr_tvalid,
    output logic [NUM_PORTS-1:0]                s_udp_hdr_trdy,
    input  logic [16*NUM_PORTS-1:0]             s_udp_src_port,
    input  logic [16*NUM_PORTS-1:0]             s_udp_dst_port,
    input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_tx_axis_tdata,
    input  logic [NUM_PORTS-1:0]                s_tx_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_tx_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_tx_axis_trdy,
    output logic                                m_udp_hdr_tvalid,
    input  logic                                m_udp_hdr_trdy,
    output logic [15:0]                         m_udp_src_port,
    output logic [15:0]                         m_udp_dst_port,
    output logic [AXI_DATA_WIDTH-1:0]           m_tx_axis_tdata,
    output logic                                m_tx_axis_tvalid,
    output logic                                m_tx_axis_tlast,
    input  logic                                m_tx_axis_trdy,
    output logic                                o_busy,
    output logic [GRANT_W-1:0]                  o_grant
);
    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, sel_idx;
    udp_port_t          src_q, src_d, dst_q, dst_d;
    logic               sel_found, in_pay;

    rr_priority_select #(.N(NUM_PORTS), .GW(GRANT_W)) u_sel (
        .req   (s_udp_hdr_tvalid),
        .ptr   (rr_ptr_q),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        src_d            = src_q;
        dst_d            = dst_q;
        s_udp_hdr_trdy   = '0;
        s_tx_axis_trdy   = '0;
        in_pay           = state_q == PAYLOAD;
        m_udp_hdr_tvalid = state_q == HDR;
        m_udp_src_port   = src_q;
        m_udp_dst_port   = dst_q;
        m_tx_axis_tdata  = s_tx_axis_tdata[grant_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        m_tx_axis_tvalid = in_pay & s_tx_axis_tvalid[grant_q];
        m_tx_axis_tlast  = in_pay & s_tx_axis_tlast[grant_q];
        case (state_q)
            // No header is acknowledged while reset is held: it would be discarded at the edge.
            IDLE: if (sel_found && i_reset_n) begin
                s_udp_hdr_trdy[sel_idx] = 1'b1;
                src_d   = s_udp_src_port[sel_idx*16 +: 16];
                dst_d   = s_udp_dst_port[sel_idx*16 +: 16];
                grant_d = sel_idx;
                state_d = HDR;
            end
            HDR: if (m_udp_hdr_trdy) state_d = PAYLOAD;
            PAYLOAD: begin
                s_tx_axis_trdy[grant_q] = m_tx_axis_trdy;
                if (m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast) begin
                    rr_ptr_d = (grant_q == GRANT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
        end
    end

    assign o_busy  = state_q != IDLE;
    assign o_grant = grant_q;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench for the 4-client udp_tx_arbiter
module tb_udp_tx_arbiter;
    localparam int NP = 4;
    localparam int W  = 8;

    typedef struct {logic [15:0] src; logic [15:0] dst; int g;} hdr_t;
    typedef struct {logic [7:0] d; logic l; int g;} beat_t;
    typedef struct {int c; logic [15:0] src; logic [15:0] dst; int len; logic [7:0] base; int exp_g;} vec_t;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic [NP-1:0]     s_udp_hdr_tvalid, s_udp_hdr_trdy;
    logic [16*NP-1:0]  s_udp_src_port, s_udp_dst_port;
    logic [W*NP-1:0]   s_tx_axis_tdata;
    logic [NP-1:0]     s_tx_axis_tvalid, s_tx_axis_tlast, s_tx_axis_trdy;
    logic              m_udp_hdr_tvalid, m_udp_hdr_trdy;
    logic [15:0]       m_udp_src_port, m_udp_dst_port;
    logic [W-1:0]      m_tx_axis_tdata;
    logic              m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_trdy;
    logic              o_busy;
    logic [1:0]        o_grant;

    hdr_t        exp_h[$];
    beat_t       exp_b[$];
    hdr_t        eh;
    beat_t       eb;
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] hbuf[NP][16];
    logic [8:0]  pbuf[NP][64];
    int          hh[NP], ht[NP], ph[NP], pt[NP];
    logic [NP-1:0] hs_h, hs_p;
    logic        tog, in_pay;
    int          cur_g;
    vec_t        tv[8];
    int          fair_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int          n;

    udp_tx_arbiter #(.NUM_PORTS(NP), .AXI_DATA_WIDTH(W)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .s_udp_hdr_tvalid (s_udp_hdr_tvalid),
        .s_udp_hdr_trdy   (s_udp_hdr_trdy),
        .s_udp_src_port   (s_udp_src_port),
        .s_udp_dst_port   (s_udp_dst_port),
        .s_tx_axis_tdata  (s_tx_axis_tdata),
        .s_tx_axis_tvalid (s_tx_axis_tvalid),
        .s_tx_axis_tlast  (s_tx_axis_tlast),
        .s_tx_axis_trdy   (s_tx_axis_trdy),
        .m_udp_hdr_tvalid (m_udp_hdr_tvalid),
        .m_udp_hdr_trdy   (m_udp_hdr_trdy),
        .m_udp_src_port   (m_udp_src_port),
        .m_udp_dst_port   (m_udp_dst_port),
        .m_tx_axis_tdata  (m_tx_axis_tdata),
        .m_tx_axis_tvalid (m_tx_axis_tvalid),
        .m_tx_axis_tlast  (m_tx_axis_tlast),
        .m_tx_axis_trdy   (m_tx_axis_trdy),
        .o_busy           (o_busy),
        .o_grant          (o_grant)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int c, input logic [15:0] s, input logic [15:0] d,
                        input int len, input logic [7:0] base, input int g);
        hbuf[c][ht[c]] = {s, d};
        ht[c]++;
        exp_h.push_back('{s, d, g});
        for (int k = 0; k < len; k++) begin
            pbuf[c][pt[c]] = {k == len - 1, base + 8'(k)};
            pt[c]++;
            exp_b.push_back('{base + 8'(k), k == len - 1, g});
        end
    endtask

    task automatic flush();
        for (int c = 0; c < NP; c++) begin
            hh[c] = 0; ht[c] = 0; ph[c] = 0; pt[c] = 0;
        end
        hs_h = '0;
        hs_p = '0;
        exp_h.delete();
        exp_b.delete();
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while ((exp_h.size() != 0 || exp_b.size() != 0) && k < 400) begin
            @(negedge i_clk);
            k++;
        end
        checks++;
        if (exp_h.size() != 0 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL %s timeout: pending headers=%0d beats=%0d", nm, exp_h.size(), exp_b.size());
            exp_h.delete();
            exp_b.delete();
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        flush();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    // Client and sink model: advance on handshakes seen at the previous falling edge.
    always begin
        @(posedge i_clk);
        #2;
        for (int c = 0; c < NP; c++) begin
            if (hs_h[c] && hh[c] < ht[c]) hh[c]++;
            if (hs_p[c] && ph[c] < pt[c]) ph[c]++;
            s_udp_hdr_tvalid[c] = hh[c] < ht[c];
            {s_udp_src_port[c*16 +: 16], s_udp_dst_port[c*16 +: 16]} = (hh[c] < ht[c]) ? hbuf[c][hh[c]] : 32'h0;
            s_tx_axis_tvalid[c] = ph[c] < pt[c];
            {s_tx_axis_tlast[c], s_tx_axis_tdata[c*W +: W]} = (ph[c] < pt[c]) ? pbuf[c][ph[c]] : 9'h0;
        end
        hs_h = '0;
        hs_p = '0;
        m_tx_axis_trdy = tog ? ~m_tx_axis_trdy : 1'b1;
    end

    // Monitor: scoreboard pops on master handshakes; payload ready must only mirror to the granted client.
    always @(negedge i_clk) begin
        chk("s_tx_trdy_route", 32'(s_tx_axis_trdy), in_pay ? (32'(m_tx_axis_trdy) << cur_g) : 32'h0);
        if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
            if (exp_h.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_hdr actual=%0h expected=none", {m_udp_src_port, m_udp_dst_port});
            end else begin
                eh = exp_h.pop_front();
                chk("hdr_ports", {m_udp_src_port, m_udp_dst_port}, {eh.src, eh.dst});
                chk("hdr_grant", 32'(o_grant), 32'(eh.g));
                cur_g  = eh.g;
                in_pay = 1'b1;
            end
        end
        if (m_tx_axis_tvalid && m_tx_axis_trdy) begin
            if (exp_b.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat actual=%0h expected=none", m_tx_axis_tdata);
            end else begin
                eb = exp_b.pop_front();
                chk("beat", {o_grant, m_tx_axis_tlast, m_tx_axis_tdata}, {2'(eb.g), eb.l, eb.d});
            end
            if (m_tx_axis_tlast) in_pay = 1'b0;
        end
        hs_h = s_udp_hdr_tvalid & s_udp_hdr_trdy;
        hs_p = s_tx_axis_tvalid & s_tx_axis_trdy;
        if (!i_reset_n) in_pay = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        m_udp_hdr_trdy = 1'b1;
        m_tx_axis_trdy = 1'b1;
        tog = 1'b0;
        in_pay = 1'b0;
        cur_g = 0;
        s_udp_hdr_tvalid = '0; s_udp_src_port = '0; s_udp_dst_port = '0;
        s_tx_axis_tdata = '0; s_tx_axis_tvalid = '0; s_tx_axis_tlast = '0;
        hs_h = '0; hs_p = '0;
        for (int c = 0; c < NP; c++) begin
            hh[c] = 0; ht[c] = 0; ph[c] = 0; pt[c] = 0;
        end
        for (int i = 0; i < 8; i++)
            tv[i] = '{i % NP, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 2 + i % 3, 8'(16 * i + 1), fair_g[i]};

        do_reset();
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_trdy", {s_udp_hdr_trdy, s_tx_axis_trdy}, 0);
        chk("rst_mvalid", {m_udp_hdr_tvalid, m_tx_axis_tvalid, m_tx_axis_tlast}, 0);
        chk("rst_ports", {m_udp_src_port, m_udp_dst_port}, 0);
        @(posedge i_clk);
        #1;

        // single client
        load(0, 16'h1234, 16'h0050, 4, 8'h01, 0);
        @(negedge i_clk);
        chk("t1_hdr_trdy_same_cycle", 32'(s_udp_hdr_trdy), 32'b0001);
        @(negedge i_clk);
        chk("t1_m_hdr_valid", 32'(m_udp_hdr_tvalid), 1);
        chk("t1_busy", 32'(o_busy), 1);
        wait_done("t1");
        @(negedge i_clk);
        chk("t1_idle_busy", 32'(o_busy), 0);
        chk("t1_grant_hold", 32'(o_grant), 0);
        @(posedge i_clk);
        #1;

        // contention from reset: client 0 then client 1, never interleaved
        do_reset();
        load(0, 16'hA000, 16'hA001, 5, 8'h10, 0);
        load(1, 16'hB000, 16'hB001, 3, 8'h20, 1);
        wait_done("t2");

        // fairness wrap
        do_reset();
        for (int i = 0; i < 8; i++) load(tv[i].c, tv[i].src, tv[i].dst, tv[i].len, tv[i].base, tv[i].exp_g);
        wait_done("t3");
        @(negedge i_clk);
        chk("t3_last_grant", 32'(o_grant), 3);
        @(posedge i_clk);
        #1;

        // backpressure: header stall then toggling payload ready
        m_udp_hdr_trdy = 1'b0;
        load(2, 16'hBEEF, 16'h0035, 6, 8'h30, 2);
        @(negedge i_clk);
        repeat (5) begin
            @(negedge i_clk);
            chk("bp_hdr_valid", 32'(m_udp_hdr_tvalid), 1);
            chk("bp_hdr_ports", {m_udp_src_port, m_udp_dst_port}, 32'hBEEF0035);
        end
        @(posedge i_clk);
        #1;
        m_udp_hdr_trdy = 1'b1;
        tog = 1'b1;
        wait_done("t4");
        tog = 1'b0;

        // single-beat packet, then the next request one cycle later
        load(3, 16'h3300, 16'h3301, 1, 8'hAA, 3);
        load(0, 16'h0300, 16'h0301, 2, 8'h40, 0);
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast) break;
        end
        chk("sb_beat", {m_tx_axis_tlast, m_tx_axis_tdata}, 9'h1AA);
        @(negedge i_clk);
        chk("sb_next_hdr_trdy", 32'(s_udp_hdr_trdy), 32'b0001);
        chk("sb_idle", 32'(o_busy), 0);
        wait_done("t5");

        // reset in the middle of a 10-beat payload
        load(1, 16'h1111, 16'h1112, 10, 8'h50, 1);
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge i_clk);
            if (m_tx_axis_tvalid && m_tx_axis_trdy) n++;
        end
        chk("mr_beats_before_reset", n, 2);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        flush();
        @(negedge i_clk);
        @(negedge i_clk);
        chk("mr_trdy", {s_udp_hdr_trdy, s_tx_axis_trdy}, 0);
        chk("mr_mvalid", {m_udp_hdr_tvalid, m_tx_axis_tvalid, m_tx_axis_tlast}, 0);
        chk("mr_busy", 32'(o_busy), 0);
        chk("mr_grant", 32'(o_grant), 0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        load(0, 16'h0A0A, 16'h0B0B, 2, 8'h60, 0);
        load(1, 16'h1A1A, 16'h1B1B, 2, 8'h70, 1);
        wait_done("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
